// File: rtl/latch_bist_ctrl_pkg.sv
// Shared definitions for the latch self-test controller: FSM encoding and the
// transparency/hold step table (bit i of each vector belongs to step i).
package latch_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int STEPS = 5;

    // steps 0..4: e = 1,1,0,1,0  d = 0,1,0,0,1  q = 0,1,1,0,0
    localparam logic [STEPS-1:0] STEP_E = 5'b01011;
    localparam logic [STEPS-1:0] STEP_D = 5'b10010;
    localparam logic [STEPS-1:0] STEP_Q = 5'b00110;

endpackage

// File: rtl/latch_bist_ctrl_sync.sv
// Two-flop synchronizer for a signal asynchronous to clk; clears to 0 on reset.
module latch_bist_ctrl_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/latch_bist_ctrl.sv
// Self-test controller for a level-sensitive D latch: walks the step table LOOPS
// times, checks synchronized q/qb after each settle window and reports the result.
module latch_bist_ctrl
    import latch_bist_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int LOOPS      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [2:0] err_step,
    output logic       lat_e,
    output logic       lat_d,
    input  logic       lat_q,
    input  logic       lat_qb
);

    state_t     state, state_nxt;
    logic [2:0] step, step_nxt;
    logic [7:0] loop, loop_nxt;
    logic [7:0] settle, settle_nxt;
    logic [7:0] err_cnt_nxt;
    logic [2:0] err_step_nxt;
    logic       pass_nxt, e_nxt, d_nxt;
    logic       sync_q, sync_qb, mismatch;

    latch_bist_ctrl_sync u_sync_q  (.clk(clk), .rst_n(rst_n), .din(lat_q),  .dout(sync_q));
    latch_bist_ctrl_sync u_sync_qb (.clk(clk), .rst_n(rst_n), .din(lat_qb), .dout(sync_qb));

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign mismatch = (sync_q != STEP_Q[step]) || (sync_qb != ~sync_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step     <= '0;
            loop     <= '0;
            settle   <= '0;
            err_cnt  <= '0;
            err_step <= '0;
            pass     <= 1'b0;
            lat_e    <= 1'b0;
            lat_d    <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            loop     <= loop_nxt;
            settle   <= settle_nxt;
            err_cnt  <= err_cnt_nxt;
            err_step <= err_step_nxt;
            pass     <= pass_nxt;
            lat_e    <= e_nxt;
            lat_d    <= d_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        loop_nxt     = loop;
        settle_nxt   = settle;
        err_cnt_nxt  = err_cnt;
        err_step_nxt = err_step;
        pass_nxt     = pass;
        e_nxt        = lat_e;
        d_nxt        = lat_d;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_DRIVE;
                    step_nxt     = '0;
                    loop_nxt     = '0;
                    err_cnt_nxt  = '0;
                    err_step_nxt = '0;
                    pass_nxt     = 1'b0;
                    e_nxt        = STEP_E[0];
                    d_nxt        = STEP_D[0];
                end
            end
            ST_DRIVE: begin
                settle_nxt = 8'(SETTLE_CYC - 1);
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (settle == 8'd0) state_nxt = ST_CHECK;
                else                settle_nxt = settle - 8'd1;
            end
            ST_CHECK: begin
                // err_cnt never returns to zero within a run, so zero marks the first error
                if (mismatch) begin
                    if (err_cnt == 8'd0)   err_step_nxt = step;
                    if (err_cnt != 8'd255) err_cnt_nxt  = err_cnt + 8'd1;
                end
                if (step < 3'(STEPS - 1)) begin
                    step_nxt  = step + 3'd1;
                    e_nxt     = STEP_E[step_nxt];
                    d_nxt     = STEP_D[step_nxt];
                    state_nxt = ST_DRIVE;
                end else if (int'(loop) < LOOPS - 1) begin
                    loop_nxt  = loop + 8'd1;
                    step_nxt  = '0;
                    e_nxt     = STEP_E[0];
                    d_nxt     = STEP_D[0];
                    state_nxt = ST_DRIVE;
                end else begin
                    e_nxt     = 1'b0;
                    d_nxt     = 1'b0;
                    pass_nxt  = (err_cnt_nxt == 8'd0);
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_latch_bist_ctrl.sv
// Directed bench: four controller instances with different parameters, each paired
// with a behavioural D latch whose outputs can be faulted.
module tb_latch_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start_v = '0;
    logic [3:0] busy_v, done_v, pass_v, le_v, ld_v;
    logic [7:0] errc [4];
    logic [2:0] estep [4];
    logic [1:0] fmode [4];   // 0 ideal, 1 q stuck-at-0, 2 qb shorted to q

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic qm, qo, qbo;
        always_latch if (le_v[g]) qm <= ld_v[g];
        assign qo  = (fmode[g] == 2'd1) ? 1'b0 : qm;
        assign qbo = (fmode[g] == 2'd2) ? qo : ~qo;

        latch_bist_ctrl #(
            .SETTLE_CYC(g == 0 ? 4 : 2),
            .LOOPS     (g == 0 ? 4 : (g == 1 ? 1 : (g == 2 ? 13 : 52)))
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .pass    (pass_v[g]),
            .err_cnt (errc[g]),
            .err_step(estep[g]),
            .lat_e   (le_v[g]),
            .lat_d   (ld_v[g]),
            .lat_q   (qo),
            .lat_qb  (qbo)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // lat counts edges from the start-accepting edge (=1) to the edge entering DONE
    task automatic run(input int i, input int budget, input bit repulse, input string tag,
                       input int exp_lat, input int exp_pass, input int exp_err, input int exp_step);
        int extra_done;
        @(negedge clk); start_v[i] = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); start_v[i] = 1'b0;
        check({tag, "_busy"}, busy_v[i], 1);
        while (!done_v[i] && lat < budget) begin
            start_v[i] = repulse && (lat == 10 || lat == 50);
            @(posedge clk); lat++;
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        check({tag, "_done"}, done_v[i], 1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_pass"}, pass_v[i], exp_pass);
        check({tag, "_err_cnt"}, errc[i], exp_err);
        check({tag, "_err_step"}, estep[i], exp_step);
        check({tag, "_lat_e"}, le_v[i], 0);
        check({tag, "_lat_d"}, ld_v[i], 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done_v[i], 0);
        check({tag, "_idle"}, busy_v[i], 0);
        check({tag, "_pass_hold"}, pass_v[i], exp_pass);
        if (repulse) begin
            extra_done = 0;
            repeat (20) begin
                @(negedge clk);
                if (done_v[i]) extra_done++;
            end
            check({tag, "_no_second_done"}, extra_done, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) fmode[k] = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_pass", pass_v[0], 0);
        check("rst_err_cnt", errc[0], 0);
        check("rst_lat_e", le_v[0], 0);
        rst_n = 1'b1;

        run(0, 400, 1'b0, "ideal", 121, 1, 0, 0);
        fmode[0] = 2'd1;
        run(0, 400, 1'b0, "stuck0", 121, 0, 8, 1);
        fmode[0] = 2'd2;
        run(0, 400, 1'b0, "qb_short", 121, 0, 20, 0);
        fmode[0] = 2'd0;
        run(0, 400, 1'b1, "repulse", 121, 1, 0, 0);

        // abort a faulty run at cycle 40 so the cleared error count is observable
        fmode[0] = 2'd1;
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); start_v[0] = 1'b0;
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        check("pre_abort_err_cnt", errc[0], 2);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_pass", pass_v[0], 0);
        check("abort_err_cnt", errc[0], 0);
        check("abort_err_step", estep[0], 0);
        check("abort_lat_e", le_v[0], 0);
        check("abort_lat_d", ld_v[0], 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done_v[0], 0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("abort_stays_idle", done_v[0] | busy_v[0], 0);
        end
        fmode[0] = 2'd0;
        run(0, 400, 1'b0, "post_abort", 121, 1, 0, 0);

        run(1, 100, 1'b0, "s2_l1", 21, 1, 0, 0);
        fmode[2] = 2'd1;
        run(2, 400, 1'b0, "s2_l13_stuck", 261, 0, 26, 1);
        fmode[3] = 2'd2;
        run(3, 1200, 1'b0, "s2_l52_sat", 1041, 0, 255, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
